// File: rtl/skolem_search_bvslt_bvudiv_if.sv
// Request/result handshake bundle for the Skolem witness search.
// The master drives requests and consumes results; the slave is the search engine.
interface skolem_search_bvslt_bvudiv_if #(
  parameter int W = 4
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic [W-1:0] t;
  logic         mode;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic         found;
  logic [W:0]   cand_cnt;

  modport master (
    output in_valid, s, t, mode, abort, out_ready,
    input  in_ready, out_valid, x, found, cand_cnt
  );

  modport slave (
    input  in_valid, s, t, mode, abort, out_ready,
    output in_ready, out_valid, x, found, cand_cnt
  );
endinterface

// File: rtl/skolem_search_bvslt_bvudiv.sv
// Linear search for the smallest x with (x udiv s) <s t (mode 0) or (s udiv x) <s t (mode 1).
// One candidate per cycle; the last candidate is terminal, so the search never wraps.
module skolem_search_bvslt_bvudiv #(
  parameter int W = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  skolem_search_bvslt_bvudiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] s_reg, s_next;
  logic [W-1:0] t_reg, t_next;
  logic         mode_reg, mode_next;
  logic [W-1:0] cand_reg, cand_next;
  logic [W:0]   cnt_reg, cnt_next;
  logic [W-1:0] x_reg, x_next;
  logic         found_reg, found_next;
  logic         out_valid_reg, out_valid_next;

  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic         hit;
  logic         last_cand;

  // Division by zero yields all-ones, matching bit-vector udiv semantics.
  always_comb begin
    dividend = mode_reg ? s_reg : cand_reg;
    divisor  = mode_reg ? cand_reg : s_reg;
    if (divisor == '0) begin
      quotient = '1;
    end else begin
      quotient = dividend / divisor;
    end
    hit       = $signed(quotient) < $signed(t_reg);
    last_cand = &cand_reg;
  end

  always_comb begin
    state_next     = state_reg;
    s_next         = s_reg;
    t_next         = t_reg;
    mode_next      = mode_reg;
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    x_next         = x_reg;
    found_next     = found_reg;
    out_valid_next = out_valid_reg;

    unique case (state_reg)
      IDLE: begin
        out_valid_next = 1'b0;
        if (bus.in_valid) begin
          s_next     = bus.s;
          t_next     = bus.t;
          mode_next  = bus.mode;
          cand_next  = '0;
          cnt_next   = '0;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        // Abort beats a coinciding hit and leaves the result registers untouched.
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + (W+1)'(1);
          if (hit) begin
            x_next         = cand_reg;
            found_next     = 1'b1;
            out_valid_next = 1'b1;
            state_next     = DONE;
          end else if (last_cand) begin
            x_next         = '0;
            found_next     = 1'b0;
            out_valid_next = 1'b1;
            state_next     = DONE;
          end else begin
            cand_next = cand_reg + W'(1);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        out_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg         <= '0;
      t_reg         <= '0;
      mode_reg      <= 1'b0;
      cand_reg      <= '0;
      cnt_reg       <= '0;
      x_reg         <= '0;
      found_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      s_reg         <= s_next;
      t_reg         <= t_next;
      mode_reg      <= mode_next;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      x_reg         <= x_next;
      found_reg     <= found_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.x         = x_reg;
  assign bus.found     = found_reg;
  assign bus.cand_cnt  = cnt_reg;

endmodule

// File: tb/tb_skolem_search_bvslt_bvudiv.sv
// Random and directed requests against an exhaustive-search reference model.
// Cycle n spans rising edges n-1..n, with the accept edge as edge 0; sampling is on negedges.
module tb_skolem_search_bvslt_bvudiv;
  localparam int W = 4;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  skolem_search_bvslt_bvudiv_if #(.W(W)) bus ();

  skolem_search_bvslt_bvudiv #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int last_x = 0;
  int last_found = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (N / 2)) ? v - N : v;
  endfunction

  // Scan every candidate with plain integer arithmetic; cnt is candidates examined.
  function automatic void ref_search(input int s, input int t, input int m,
                                     output int fx, output int ff, output int fc);
    fx = 0;
    ff = 0;
    fc = N;
    for (int c = 0; c < N; c++) begin
      int num, den, q;
      num = m ? s : c;
      den = m ? c : s;
      q = (den == 0) ? N - 1 : num / den;
      if (sx(q) < sx(t)) begin
        fx = c;
        ff = 1;
        fc = c + 1;
        return;
      end
    end
  endfunction

  task automatic accept(input int s, input int t, input int m);
    @(negedge clk);
    check_val("in_ready_before_req", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.s = W'(s);
    bus.t = W'(t);
    bus.mode = m[0];
    @(posedge clk);
  endtask

  // After the accept edge, keep in_valid high with junk operands to show they are ignored.
  task automatic scramble();
    bus.in_valid = 1'b1;
    bus.s = W'($urandom);
    bus.t = W'($urandom);
    bus.mode = 1'($urandom);
  endtask

  task automatic run_req(input int s, input int t, input int m, input int hold);
    int fx, ff, fc, cyc, rise;
    ref_search(s, t, m, fx, ff, fc);
    accept(s, t, m);
    @(negedge clk);
    cyc = 1;
    scramble();
    while (!bus.out_valid && cyc < N + 8) begin
      @(negedge clk);
      cyc++;
      scramble();
    end
    rise = bus.out_valid ? cyc : -1;
    bus.in_valid = 1'b0;
    check_val("out_valid_rise_cycle", rise, fc + 1);
    check_val("x", int'(bus.x), fx);
    check_val("found", int'(bus.found), ff);
    check_val("cand_cnt", int'(bus.cand_cnt), fc);
    for (int i = 0; i < hold; i++) begin
      bus.abort = 1'($urandom);
      @(negedge clk);
      check_val("hold_out_valid", int'(bus.out_valid), 1);
      check_val("hold_x", int'(bus.x), fx);
      check_val("hold_found", int'(bus.found), ff);
      check_val("hold_cand_cnt", int'(bus.cand_cnt), fc);
    end
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val("release_out_valid", int'(bus.out_valid), 0);
    check_val("release_in_ready", int'(bus.in_ready), 1);
    last_x = fx;
    last_found = ff;
    $display("REQ mode=%0d s=%0d t=%0d -> x=%0d found=%0d cnt=%0d rise=%0d hold=%0d",
             m, s, t, bus.x, bus.found, bus.cand_cnt, rise, hold);
  endtask

  // Abort is sampled at edge a (driven during cycle a); a must not exceed the hit edge.
  task automatic run_abort(input int s, input int t, input int m, input int a);
    accept(s, t, m);
    for (int cyc = 1; cyc <= a; cyc++) begin
      @(negedge clk);
      scramble();
      bus.in_valid = 1'b0;
      check_val("abort_no_out_valid", int'(bus.out_valid), 0);
      if (cyc == a) bus.abort = 1'b1;
    end
    @(negedge clk);
    bus.abort = 1'b0;
    check_val("abort_in_ready", int'(bus.in_ready), 1);
    check_val("abort_out_valid", int'(bus.out_valid), 0);
    check_val("abort_cand_cnt", int'(bus.cand_cnt), a - 1);
    check_val("abort_x_held", int'(bus.x), last_x);
    check_val("abort_found_held", int'(bus.found), last_found);
    repeat (2) begin
      @(negedge clk);
      check_val("abort_idle_out_valid", int'(bus.out_valid), 0);
    end
    $display("ABORT mode=%0d s=%0d t=%0d at_cycle=%0d -> cnt=%0d in_ready=%0d",
             m, s, t, a, bus.cand_cnt, bus.in_ready);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_in_ready"}, int'(bus.in_ready), 1);
    check_val({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check_val({tag, "_x"}, int'(bus.x), 0);
    check_val({tag, "_found"}, int'(bus.found), 0);
    check_val({tag, "_cand_cnt"}, int'(bus.cand_cnt), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.s = '0;
    bus.t = '0;
    bus.mode = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req(1, 0, 0, 0);
    run_req(0, 0, 0, 0);
    run_req(3, 0, 0, 0);
    run_req(12, 8, 1, 5);
    run_abort(3, 0, 0, 4);
    run_req(3, 0, 0, 1);

    // Asynchronous reset in the middle of a search.
    accept(1, 0, 0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    check_reset_vals("midreset_held");
    rst_n = 1'b1;
    last_x = 0;
    last_found = 0;
    run_req(1, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int s, t, m, fx, ff, fc;
      s = int'($urandom_range(N - 1));
      t = int'($urandom_range(N - 1));
      m = int'($urandom_range(1));
      ref_search(s, t, m, fx, ff, fc);
      if ($urandom_range(3) == 0) begin
        run_abort(s, t, m, int'($urandom_range(fc, 1)));
      end else begin
        run_req(s, t, m, int'($urandom_range(3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/skolem_search_bvslt_bvudiv.md
SKOLEM_SEARCH_BVSLT_BVUDIV -- requirements
Module: skolem_search_bvslt_bvudiv

Interface
REQ-001 SHALL have parameter W, default 4: bit width of s, t and x; legal range 2..16.
REQ-002 SHALL have input clk, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input in_valid, 1 bit: the request on s, t and mode is valid.
REQ-005 SHALL have output in_ready, 1 bit: the block can accept a request.
REQ-006 SHALL have input s, W bits: fixed operand.
REQ-007 SHALL have input t, W bits: signed bound.
REQ-008 SHALL have input mode, 1 bit: 0 means the constraint is (x udiv s) <s t; 1 means the constraint is (s udiv x) <s t.
REQ-009 SHALL have input abort, 1 bit: synchronous cancel of the current search.
REQ-010 SHALL have output out_valid, 1 bit: the result is valid.
REQ-011 SHALL have input out_ready, 1 bit: the consumer accepts the result.
REQ-012 SHALL have output x, W bits: the Skolem witness.
REQ-013 SHALL have output found, 1 bit: a witness exists.
REQ-014 SHALL have output cand_cnt, W+1 bits: number of candidates evaluated for the current or last request.

Function
REQ-015 SHALL implement the FSM states IDLE, SEARCH and DONE; in_ready SHALL equal (state==IDLE).
REQ-016 In IDLE, when in_valid=1 the block SHALL accept the request: latch s, t and mode, clear cand_cnt and the candidate register, and go to SEARCH.
REQ-017 In SEARCH, the block SHALL evaluate exactly one candidate c per cycle, in the order 0, 1, ..., 2^W-1.
REQ-018 The constraint on each candidate c SHALL be evaluated combinationally in the same cycle.
REQ-019 cand_cnt SHALL increment once per evaluated candidate.
REQ-020 Division SHALL follow SMT-LIB semantics: a udiv 0 yields all-ones; a udiv b is otherwise the unsigned floor quotient, W bits.
REQ-021 The comparison <s SHALL be two's-complement signed less-than on W bits.
REQ-022 First hit on candidate k: the block SHALL register x=k and found=1, then go to DONE.
- Taking the accept edge as cycle 0, out_valid SHALL be high from cycle k+2.
REQ-023 Exhaustion (candidate 2^W-1 fails): the block SHALL register x=0 and found=0, then go to DONE.
- out_valid SHALL be high from cycle 2^W+1.
- cand_cnt SHALL read 2^W.
REQ-024 Candidate counter wrap SHALL NOT cause a second pass; evaluation of candidate 2^W-1 SHALL be terminal.
REQ-025 In DONE, out_valid=1 and x, found and cand_cnt SHALL stay stable while out_ready=0.
REQ-026 In DONE, when out_ready=1 the block SHALL return to IDLE on the next edge, with out_valid=0 in the following cycle.
REQ-027 abort=1 in SEARCH SHALL force the next state to IDLE with no result produced; x, found and cand_cnt SHALL hold their last values.
REQ-028 abort SHALL be ignored in IDLE and in DONE.
REQ-029 If abort=1 coincides with a hit cycle, abort SHALL win.
REQ-030 in_valid SHALL be ignored outside IDLE; inputs s, t and mode SHALL NOT affect an in-flight search.
REQ-031 out_valid SHALL be registered; in_ready SHALL be a decode of the state register only.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, x=0, found=0, cand_cnt=0.
REQ-033 Reset asserted mid-SEARCH or in DONE SHALL discard the operation.
REQ-034 After reset release, the first request SHALL be accepted on the first rising edge with in_valid=1.

Verification (W=4)
REQ-035 Hit case: mode=0, s=1, t=0 -> x=8, found=1, cand_cnt=9, out_valid rises in cycle 10.
REQ-036 Trivial hit: mode=0, s=0, t=0 -> all-ones (-1) <s 0 holds, so x=0, found=1, out_valid rises in cycle 2.
REQ-037 Exhaustion: mode=0, s=3, t=0 -> found=0, x=0, cand_cnt=16, out_valid rises in cycle 17.
REQ-038 Impossible bound: mode=1, s=12, t=8 (-8) -> found=0 after 16 candidates; out_ready held low 5 cycles keeps out_valid, x and found stable.
REQ-039 abort asserted in cycle 4 of REQ-037's stimulus -> IDLE in cycle 5, no out_valid pulse; the next request is accepted normally.
REQ-040 rst_n pulsed low mid-search -> out_valid=0, in_ready=1 while low; after release, REQ-035's stimulus reproduces its result exactly.
